// File: rtl/shell_impact_judge_pkg.sv
// Shared tank-game definitions: FSM states, turn encoding, HP width and the
// target-mask helper that maps a shooter onto the opponent's bitmap half.
package shell_impact_judge_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FLIGHT = 2'd1,
      SHOW   = 2'd2,
      OVER   = 2'd3
   } state_t;

   localparam logic TURN_TANK1 = 1'b0;
   localparam logic TURN_TANK2 = 1'b1;
   localparam int   HP_W       = 2;

   // tank1 owns bitmap bits [7:4], tank2 owns [3:0]; the shooter targets the other half
   function automatic logic [7:0] target_mask(input logic       turn,
                                              input logic [3:0] tank1_location,
                                              input logic [3:0] tank2_location);
      return (turn == TURN_TANK1) ? {4'b0000, tank2_location}
                                  : {tank1_location, 4'b0000};
   endfunction

endpackage

// File: rtl/shell_impact_judge_hold_timer.sv
// Terminal-count hold timer: clear zeroes the count, en advances it, done is a
// combinational pulse on the last counted cycle (count wraps back to 0 there).
module hold_timer #(
   parameter int CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic en,
   output logic done
);

   localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
   localparam logic [W-1:0] LAST = W'(CYCLES - 1);

   logic [W-1:0] count;

   assign done = en && (count == LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (en) begin
         count <= done ? '0 : count + W'(1);
      end
   end

endmodule

// File: rtl/shell_impact_judge.sv
// Resolves a shell landing on the falling edge of fire, scores HP, holds a
// hit/miss flag for SHOW_CYCLES cycles, then passes the turn or ends the game.
module shell_impact_judge
   import shell_impact_judge_pkg::*;
#(
   parameter int HP_INIT     = 3,
   parameter int SHOW_CYCLES = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            fire,
   input  logic [7:0]      shell,
   input  logic [3:0]      tank1_location,
   input  logic [3:0]      tank2_location,
   output logic            turn,
   output logic [HP_W-1:0] hp1,
   output logic [HP_W-1:0] hp2,
   output logic            hit_flag,
   output logic            miss_flag,
   output logic            game_over,
   output logic            winner
);

   state_t          state;
   logic [7:0]      shell_last;
   logic [7:0]      target;
   logic            landed;
   logic            in_show;
   logic            show_done;
   logic [HP_W-1:0] target_hp;

   assign target    = target_mask(turn, tank1_location, tank2_location);
   assign landed    = (state == FLIGHT) && !fire;
   assign in_show   = (state == SHOW);
   assign target_hp = (turn == TURN_TANK1) ? hp2 : hp1;

   hold_timer #(
      .CYCLES(SHOW_CYCLES)
   ) u_hold_timer (
      .clk  (clk),
      .rst  (rst),
      .clear(landed),
      .en   (in_show),
      .done (show_done)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         turn       <= TURN_TANK1;
         hp1        <= HP_W'(HP_INIT);
         hp2        <= HP_W'(HP_INIT);
         hit_flag   <= 1'b0;
         miss_flag  <= 1'b0;
         game_over  <= 1'b0;
         winner     <= 1'b0;
         shell_last <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (fire) begin
                  shell_last <= shell;
                  state      <= FLIGHT;
               end
            end
            FLIGHT: begin
               if (fire) begin
                  shell_last <= shell;
               end else begin
                  // score from the last in-flight sample; the live bus may already have moved on
                  if (|(shell_last & target)) begin
                     hit_flag <= 1'b1;
                     if (turn == TURN_TANK1) begin
                        hp2 <= (hp2 != '0) ? hp2 - HP_W'(1) : hp2;
                     end else begin
                        hp1 <= (hp1 != '0) ? hp1 - HP_W'(1) : hp1;
                     end
                  end else begin
                     miss_flag <= 1'b1;
                  end
                  state <= SHOW;
               end
            end
            SHOW: begin
               if (show_done) begin
                  hit_flag  <= 1'b0;
                  miss_flag <= 1'b0;
                  if (target_hp == '0) begin
                     game_over <= 1'b1;
                     winner    <= turn;
                     state     <= OVER;
                  end else begin
                     turn  <= ~turn;
                     state <= IDLE;
                  end
               end
            end
            OVER: begin
               state <= OVER;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shell_impact_judge.sv
// Directed and randomized shots against a turn/HP scoreboard model.
module tb_shell_impact_judge;

   localparam int HP_INIT = 3;
   localparam int SHOW    = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic       fire;
   logic [7:0] shell;
   logic [3:0] tank1_location;
   logic [3:0] tank2_location;
   logic       turn;
   logic [1:0] hp1;
   logic [1:0] hp2;
   logic       hit_flag;
   logic       miss_flag;
   logic       game_over;
   logic       winner;

   int errors = 0;
   int checks = 0;

   // reference model state
   int m_turn;
   int m_hp1;
   int m_hp2;
   int m_over;
   int m_winner;
   int m_hit;

   shell_impact_judge #(
      .HP_INIT    (HP_INIT),
      .SHOW_CYCLES(SHOW)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .fire          (fire),
      .shell         (shell),
      .tank1_location(tank1_location),
      .tank2_location(tank2_location),
      .turn          (turn),
      .hp1           (hp1),
      .hp2           (hp2),
      .hit_flag      (hit_flag),
      .miss_flag     (miss_flag),
      .game_over     (game_over),
      .winner        (winner)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".turn"}, 8'(turn), 8'(m_turn));
      chk({tag, ".hp1"}, 8'(hp1), 8'(m_hp1));
      chk({tag, ".hp2"}, 8'(hp2), 8'(m_hp2));
      chk({tag, ".game_over"}, 8'(game_over), 8'(m_over));
      if (m_over != 0) chk({tag, ".winner"}, 8'(winner), 8'(m_winner));
   endtask

   task automatic model_reset();
      m_turn = 0; m_hp1 = HP_INIT; m_hp2 = HP_INIT;
      m_over = 0; m_winner = 0; m_hit = 0;
   endtask

   task automatic do_reset();
      fire = 1'b0; shell = '0; tank1_location = '0; tank2_location = '0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      model_reset();
      tick();
      chk_all("reset");
      chk("reset.hit_flag", 8'(hit_flag), 8'd0);
      chk("reset.miss_flag", 8'(miss_flag), 8'd0);
      chk("reset.winner", 8'(winner), 8'd0);
   endtask

   // Flight of len cycles ending on shell value last, then landing with the bus showing after.
   task automatic launch(input int len, input logic [7:0] last, input logic [7:0] after,
                         input logic [3:0] t1, input logic [3:0] t2);
      logic [7:0] tgt;
      for (int i = 0; i < len; i++) begin
         fire = 1'b1;
         shell = (i == len - 1) ? last : 8'($urandom);
         tank1_location = 4'($urandom);
         tank2_location = 4'($urandom);
         tick();
         chk("flight.hit_flag", 8'(hit_flag), 8'd0);
         chk("flight.miss_flag", 8'(miss_flag), 8'd0);
         chk("flight.hp1", 8'(hp1), 8'(m_hp1));
         chk("flight.hp2", 8'(hp2), 8'(m_hp2));
      end
      fire = 1'b0;
      shell = after;
      tank1_location = t1;
      tank2_location = t2;
      tgt = (m_turn == 0) ? {4'b0000, t2} : {t1, 4'b0000};
      m_hit = ((last & tgt) != 8'd0) ? 1 : 0;
      if (m_hit != 0) begin
         if (m_turn == 0) begin
            if (m_hp2 > 0) m_hp2--;
         end else begin
            if (m_hp1 > 0) m_hp1--;
         end
      end
      tick();
      tank1_location = 4'($urandom);
      tank2_location = 4'($urandom);
      chk("land.hit_flag", 8'(hit_flag), 8'(m_hit));
      chk("land.miss_flag", 8'(miss_flag), 8'(m_hit == 0));
      chk_all("land");
   endtask

   // Rest of the display window; optionally waves fire mid-window, which must be ignored.
   task automatic finish_window(input bit show_fire);
      for (int c = 0; c < SHOW - 1; c++) begin
         fire = show_fire && (c >= 3) && (c <= 5);
         shell = 8'($urandom);
         tick();
         chk("window.hit_flag", 8'(hit_flag), 8'(m_hit));
         chk("window.miss_flag", 8'(miss_flag), 8'(m_hit == 0));
         chk("window.turn", 8'(turn), 8'(m_turn));
      end
      fire = 1'b0;
      tick();
      if (((m_turn == 0) ? m_hp2 : m_hp1) == 0) begin
         m_over = 1;
         m_winner = m_turn;
      end else begin
         m_turn = 1 - m_turn;
      end
      chk("end.hit_flag", 8'(hit_flag), 8'd0);
      chk("end.miss_flag", 8'(miss_flag), 8'd0);
      chk_all("end");
   endtask

   task automatic check_frozen();
      for (int i = 0; i < 8; i++) begin
         fire = 1'($urandom);
         shell = 8'($urandom);
         tank1_location = 4'($urandom);
         tank2_location = 4'($urandom);
         tick();
         chk_all("over");
         chk("over.hit_flag", 8'(hit_flag), 8'd0);
         chk("over.miss_flag", 8'(miss_flag), 8'd0);
      end
      fire = 1'b0;
   endtask

   initial begin
      rst = 1'b1; fire = 1'b0; shell = '0; tank1_location = '0; tank2_location = '0;
      model_reset();

      // Test 1: tank1 hits tank2
      do_reset();
      launch(3, 8'b0000_0100, 8'b0000_0000, 4'b0000, 4'b0100);
      finish_window(1'b0);

      // Test 2: tank2 misses tank1
      launch(2, 8'b0100_0000, 8'b0100_0000, 4'b0001, 4'b0000);
      finish_window(1'b0);

      // Test 3: bus goes to zero on the landing edge, last in-flight value still counts
      launch(2, 8'b0000_0100, 8'b0000_0000, 4'b0000, 4'b0100);
      finish_window(1'b0);

      // Test 6: single-cycle pulse by tank2, extra fire during the window
      launch(1, 8'b1000_0000, 8'b0000_0000, 4'b1000, 4'b0000);
      finish_window(1'b1);

      // empty bitmap at landing is a miss
      launch(1, 8'b0000_0000, 8'hFF, 4'b1111, 4'b1111);
      finish_window(1'b0);

      // Test 4: three tank1 hits, tank2 always misses on an empty target
      do_reset();
      for (int s = 0; s < 3; s++) begin
         launch(2, 8'b0000_0001, 8'h00, 4'b0000, 4'b0001);
         finish_window(1'b0);
         if (s < 2) begin
            launch(1, 8'hFF, 8'hFF, 4'b0000, 4'b1111);
            finish_window(1'b0);
         end
      end
      chk("t4.game_over", 8'(game_over), 8'd1);
      chk("t4.winner", 8'(winner), 8'd0);
      chk("t4.hp2", 8'(hp2), 8'd0);
      check_frozen();

      // Test 5: reset five cycles into a hit window
      do_reset();
      launch(2, 8'b0000_0100, 8'b0000_0000, 4'b0000, 4'b0100);
      for (int c = 0; c < 5; c++) tick();
      rst = 1'b1;
      #1;
      model_reset();
      chk("t5.hit_flag", 8'(hit_flag), 8'd0);
      chk("t5.miss_flag", 8'(miss_flag), 8'd0);
      chk_all("t5");
      tick();
      rst = 1'b0;
      tick();
      chk_all("t5.after");

      // randomized games
      for (int g = 0; g < 4; g++) begin
         do_reset();
         for (int s = 0; s < 40 && m_over == 0; s++) begin
            logic [3:0] t1;
            logic [3:0] t2;
            logic [7:0] last;
            t1 = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom);
            t2 = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom);
            if ($urandom_range(0, 1) == 1)
               last = (m_turn == 0) ? {4'b0000, t2} : {t1, 4'b0000};
            else
               last = 8'($urandom);
            launch($urandom_range(1, 4), last, 8'($urandom), t1, t2);
            finish_window(1'($urandom));
         end
         if (m_over != 0) check_frozen();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/shell_impact_judge.md
# shell_impact_judge

Receiving end of the shell-flight path in the tank game. It watches the cannon's `fire` pulse and the 8-bit shell bitmap while the shell is in flight, and resolves the landing against the opposing tank's position. On a hit it decrements that tank's hit points. It holds a hit/miss indication for a fixed display window, then passes the turn to the other tank, or ends the game when a tank reaches zero HP.

## Interface
- `HP_INIT`, 3: starting hit points per tank; legal range 1..3.
- `SHOW_CYCLES`, 16: length of the hit/miss display window, in clock cycles; must be ≥ 2.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `fire` in 1: high while a shell is in flight; the falling edge marks landing.
- `shell` in 8: shell position bitmap; bit 7 is tank1's side, bit 0 is tank2's side.
- `tank1_location` in 4: tank1 occupancy, mapped onto bitmap bits [7:4].
- `tank2_location` in 4: tank2 occupancy, mapped onto bitmap bits [3:0].
- `turn` out 1: shooter; 0 = tank1, 1 = tank2.
- `hp1`, `hp2` out 2: remaining hit points of tank1 and tank2.
- `hit_flag` out 1: high during the display window after a hit.
- `miss_flag` out 1: high during the display window after a miss.
- `game_over` out 1: sticky until reset.
- `winner` out 1: winning tank (0 = tank1, 1 = tank2); valid only while `game_over` = 1.

## Operation
- FSM states: IDLE, FLIGHT, SHOW, OVER.
- IDLE: when `fire` = 1 is sampled, capture `shell` into `shell_last` and go to FLIGHT.
- FLIGHT, `fire` = 1: capture `shell` into `shell_last` every cycle.
- FLIGHT, `fire` = 0: resolve the landing using `shell_last`, never the live `shell`.
  - Target mask is {4'b0000, `tank2_location`} when `turn` = 0, and {`tank1_location`, 4'b0000} when `turn` = 1.
  - Hit = |(`shell_last` & target).
  - On a hit, decrement the target's HP by 1, saturating at 0, and set `hit_flag`.
  - On a miss, set `miss_flag` and leave HP unchanged.
  - Clear the hold counter and go to SHOW.
- SHOW: the counter increments each cycle. On the cycle the counter equals `SHOW_CYCLES`-1:
  - Clear both flags.
  - If the target's HP is 0, set `game_over`, set `winner` = `turn`, and go to OVER.
  - Otherwise toggle `turn` and go to IDLE.
- OVER: terminal. All outputs are frozen and `fire` is ignored; only `rst` exits.
- `fire` is ignored in SHOW and OVER. A shell still in flight when SHOW ends is only seen as a new shot if `fire` is still high on arrival in IDLE.
- Tank locations are sampled only on the resolution edge; changes at any other time have no effect.
- `shell_last` = 0 at resolution is a miss.
- `tank*_location` = 0 gives an empty target mask, so the shot is a guaranteed miss.

## Timing
- Reset values:
  - State IDLE; `turn` 0; `hp1` = `hp2` = `HP_INIT`.
  - `hit_flag`, `miss_flag`, `game_over`, `winner` all 0.
  - `shell_last` 0; hold counter 0.
- Reset mid-operation restores the reset values immediately. Any shot in progress is discarded, with no HP change.
- Landing latency: if `fire` is first sampled low at edge N, HP and the flag update at edge N and are visible after it.
- Shortest shot: a 1-cycle `fire` pulse sampled at edge K moves the FSM to FLIGHT at K and resolves at K+1.
- Flags stay high for exactly `SHOW_CYCLES` cycles.
- `turn` toggles, or `game_over` rises, at the same edge the flags fall.
- Turn period: the next shot can be accepted one cycle after `turn` changes.
- Width rules:
  - The HP decrement never wraps below 0.
  - The hold counter is $clog2(`SHOW_CYCLES`) bits wide.
  - The target mask is always exactly 8 bits.

## Structure
- Shared game package holds:
  - The state enum (IDLE/FLIGHT/SHOW/OVER).
  - TURN_TANK1 = 0 and TURN_TANK2 = 1.
  - A HP_W = 2 constant.
  - A target-mask function (turn, tank1_location, tank2_location → 8 bits), also to be reused by the display logic.
- One natural sub-module: `hold_timer`, a parameterized terminal-count counter with clear and a done pulse, used by SHOW.
- Everything else stays in one FSM module.

## Test plan
- Test 1, hit by tank1: reset, `tank2_location` = 4'b0100, `turn` 0. `fire` high 3 cycles with final `shell` = 8'b0000_0100, then low → `hp2` 3→2 and `hit_flag` high for 16 cycles. Then `turn` = 1 and `miss_flag` = 0 throughout.
- Test 2, miss by tank2: `turn` 1, `tank1_location` = 4'b0001 (mask 8'b0001_0000), final `shell` = 8'b0100_0000 → `miss_flag` high for 16 cycles, `hp1` unchanged, then `turn` = 0.
- Test 3, landing uses last in-flight value: `shell` changes to 8'b0000_0000 on the same edge `fire` falls, with the previous value 8'b0000_0100 on target → scored as a hit.
- Test 4, game over: three consecutive tank1 hits with tank2 always missing → after the third window, `hp2` = 0, `game_over` = 1, `winner` = 0. Further `fire` pulses change nothing.
- Test 5, reset mid-SHOW: assert `rst` 5 cycles into a hit window → `hit_flag` drops immediately, `hp1` = `hp2` = 3, `turn` = 0.
- Test 6, 1-cycle `fire` pulse plus `fire` during SHOW: the 1-cycle pulse resolves one cycle later. A second pulse issued mid-SHOW is ignored, so HP changes exactly once.
